// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Arbitrates between a load requester (r0) and a store requester (r1) for a
//   single memory access adapter. One transaction is in flight at a time:
//   IDLE (grant + latch) -> ISSUE (one-cycle task strobe) -> BUSY (wait for
//   adapter done) -> RESP (one-cycle done pulse to the granted requester).
//   Ties are resolved round-robin. Load results are byte/half/word extended.
//
// Ports
//   clk_in, rst_in         clock, asynchronous active-high reset
//   rdy_in                 global enable; every register holds while low
//   flush_pipline          synchronous abort back to IDLE, no done pulse
//   r0_*                   load requester: valid/addr/size/signed in, done/data out
//   r1_*                   store requester: valid/addr/size/data in, done out
//   have_mem_access_task   one-cycle task strobe to the adapter
//   mem_access_*           latched request fields (zero outside ISSUE/BUSY)
//   mem_access_task_done   adapter completion pulse, honoured only in BUSY
//   mem_access_data_out    adapter read data, valid with done
module mem_req_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        r0_valid,
  input  logic [31:0] r0_addr,
  input  logic [1:0]  r0_size,
  input  logic        r0_signed,
  output logic        r0_done,
  output logic [31:0] r0_data,
  input  logic        r1_valid,
  input  logic [31:0] r1_addr,
  input  logic [1:0]  r1_size,
  input  logic [31:0] r1_data,
  output logic        r1_done,
  output logic        have_mem_access_task,
  output logic [31:0] mem_access_addr,
  output logic        mem_access_rw,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_access_data,
  input  logic        mem_access_task_done,
  input  logic [31:0] mem_access_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_r, state_s, state_nx_s;
  logic        last_grant_r, last_grant_s, grant_nx_s;  // 0 = r0, 1 = r1
  logic        grant_r, grant_s;
  logic [31:0] lat_addr_r, lat_addr_s;
  logic [31:0] lat_wdata_r, lat_wdata_s;
  logic [1:0]  lat_size_r, lat_size_s;
  logic        lat_signed_r, lat_signed_s;
  logic        lat_rw_r, lat_rw_s;
  logic [31:0] result_r, result_s, result_nx_s;
  logic        drive_s;
  logic        r0_done_r, r0_done_s;
  logic        r1_done_r, r1_done_s;
  logic [31:0] r0_data_r, r0_data_s;
  logic        task_r;
  logic [31:0] out_addr_r, out_wdata_r;
  logic        out_rw_r;
  logic [1:0]  out_size_r;

  // Byte/half results take the sign bit or zero above; 2'b10 and 2'b11 are words.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    case (size)
      2'b00:   extend_load = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   extend_load = {{16{sgn & raw[15]}}, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

  // Next-state, grant/latch and next-output computation.
  always_comb begin
    state_nx_s   = state_r;
    grant_nx_s   = last_grant_r;
    grant_s      = grant_r;
    lat_addr_s   = lat_addr_r;
    lat_wdata_s  = lat_wdata_r;
    lat_size_s   = lat_size_r;
    lat_signed_s = lat_signed_r;
    lat_rw_s     = lat_rw_r;
    result_nx_s  = result_r;
    case (state_r)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          // On a tie the requester that did not win last time is served.
          if (r0_valid && r1_valid) begin
            grant_nx_s = ~last_grant_r;
          end else begin
            grant_nx_s = r1_valid;
          end
          grant_s = grant_nx_s;
          if (grant_nx_s) begin
            lat_addr_s   = r1_addr;
            lat_wdata_s  = r1_data;
            lat_size_s   = r1_size;
            lat_signed_s = 1'b0;
            lat_rw_s     = 1'b1;
          end else begin
            lat_addr_s   = r0_addr;
            lat_wdata_s  = 32'd0;
            lat_size_s   = r0_size;
            lat_signed_s = r0_signed;
            lat_rw_s     = 1'b0;
          end
          state_nx_s = ISSUE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ISSUE: state_nx_s = BUSY;
      BUSY: begin
        if (mem_access_task_done) begin
          result_nx_s = mem_access_data_out;
          state_nx_s  = RESP;
        end else begin
          state_nx_s  = BUSY;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase

    // Flush wins over everything, including a same-cycle adapter done;
    // the round-robin pointer survives it.
    state_s      = flush_pipline ? IDLE : state_nx_s;
    last_grant_s = flush_pipline ? last_grant_r : grant_nx_s;
    result_s     = flush_pipline ? result_r : result_nx_s;

    drive_s   = (state_s == ISSUE) || (state_s == BUSY);
    r0_done_s = (state_s == RESP) && !grant_s;
    r1_done_s = (state_s == RESP) && grant_s;
    r0_data_s = r0_done_s ? extend_load(result_s, lat_size_s, lat_signed_s) : r0_data_r;
  end

  // State, latched request and registered outputs; frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      grant_r      <= 1'b0;
      lat_addr_r   <= 32'd0;
      lat_wdata_r  <= 32'd0;
      lat_size_r   <= 2'd0;
      lat_signed_r <= 1'b0;
      lat_rw_r     <= 1'b0;
      result_r     <= 32'd0;
      r0_done_r    <= 1'b0;
      r1_done_r    <= 1'b0;
      r0_data_r    <= 32'd0;
      task_r       <= 1'b0;
      out_addr_r   <= 32'd0;
      out_wdata_r  <= 32'd0;
      out_rw_r     <= 1'b0;
      out_size_r   <= 2'd0;
    end else if (rdy_in) begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      grant_r      <= grant_s;
      lat_addr_r   <= lat_addr_s;
      lat_wdata_r  <= lat_wdata_s;
      lat_size_r   <= lat_size_s;
      lat_signed_r <= lat_signed_s;
      lat_rw_r     <= lat_rw_s;
      result_r     <= result_s;
      r0_done_r    <= r0_done_s;
      r1_done_r    <= r1_done_s;
      r0_data_r    <= r0_data_s;
      task_r       <= (state_s == ISSUE);
      out_addr_r   <= drive_s ? lat_addr_s  : 32'd0;
      out_wdata_r  <= drive_s ? lat_wdata_s : 32'd0;
      out_rw_r     <= drive_s ? lat_rw_s    : 1'b0;
      out_size_r   <= drive_s ? lat_size_s  : 2'd0;
    end
  end

  assign r0_done              = r0_done_r;
  assign r1_done              = r1_done_r;
  assign r0_data              = r0_data_r;
  assign have_mem_access_task = task_r;
  assign mem_access_addr      = out_addr_r;
  assign mem_access_rw        = out_rw_r;
  assign mem_access_size      = out_size_r;
  assign mem_access_data      = out_wdata_r;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: loads with extension, round-robin ties,
// flush, rdy_in freeze, adapter done outside BUSY and asynchronous reset.
module tb_mem_req_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_pipline;
  logic        r0_valid, r0_signed, r0_done;
  logic [31:0] r0_addr, r0_data;
  logic [1:0]  r0_size;
  logic        r1_valid, r1_done;
  logic [31:0] r1_addr, r1_data;
  logic [1:0]  r1_size;
  logic        have_mem_access_task, mem_access_rw, mem_access_task_done;
  logic [31:0] mem_access_addr, mem_access_data, mem_access_data_out;
  logic [1:0]  mem_access_size;

  int vectors = 0;
  int miscompares = 0;

  mem_req_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_size(r0_size), .r0_signed(r0_signed),
    .r0_done(r0_done), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_size(r1_size), .r1_data(r1_data),
    .r1_done(r1_done),
    .have_mem_access_task(have_mem_access_task), .mem_access_addr(mem_access_addr),
    .mem_access_rw(mem_access_rw), .mem_access_size(mem_access_size),
    .mem_access_data(mem_access_data), .mem_access_task_done(mem_access_task_done),
    .mem_access_data_out(mem_access_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_task"},  {31'd0, have_mem_access_task}, 32'd0);
    chk({tag, "_addr"},  mem_access_addr, 32'd0);
    chk({tag, "_rw"},    {31'd0, mem_access_rw}, 32'd0);
    chk({tag, "_size"},  {30'd0, mem_access_size}, 32'd0);
    chk({tag, "_wdata"}, mem_access_data, 32'd0);
    chk({tag, "_done"},  {30'd0, r0_done, r1_done}, 32'd0);
    chk({tag, "_r0data"}, r0_data, 32'd0);
  endtask

  // One transaction, starting from an IDLE cycle with requests already driven.
  task automatic serve(input logic exp_r1, input logic [31:0] exp_addr,
                       input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                       input int lat, input logic [31:0] rdata,
                       input logic [31:0] exp_r0data);
    step();  // ISSUE
    chk("issue_task",  {31'd0, have_mem_access_task}, 32'd1);
    chk("issue_addr",  mem_access_addr, exp_addr);
    chk("issue_rw",    {31'd0, mem_access_rw}, {31'd0, exp_r1});
    chk("issue_size",  {30'd0, mem_access_size}, {30'd0, exp_size});
    chk("issue_wdata", mem_access_data, exp_wdata);
    step();  // BUSY
    chk("busy_task",   {31'd0, have_mem_access_task}, 32'd0);
    chk("busy_addr",   mem_access_addr, exp_addr);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("busy_wait_done", {30'd0, r0_done, r1_done}, 32'd0);
    end
    mem_access_task_done = 1'b1;
    mem_access_data_out  = rdata;
    step();  // RESP
    mem_access_task_done = 1'b0;
    mem_access_data_out  = 32'h0;
    chk("resp_r0_done", {31'd0, r0_done}, {31'd0, ~exp_r1});
    chk("resp_r1_done", {31'd0, r1_done}, {31'd0, exp_r1});
    chk("resp_r0_data", r0_data, exp_r0data);
    chk("resp_addr",    mem_access_addr, 32'd0);
    step();  // IDLE
    chk("idle_done",    {30'd0, r0_done, r1_done}, 32'd0);
    chk("idle_r0_data", r0_data, exp_r0data);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0;
    r0_valid = 1'b0; r0_addr = 32'h0; r0_size = 2'd0; r0_signed = 1'b0;
    r1_valid = 1'b0; r1_addr = 32'h0; r1_size = 2'd0; r1_data = 32'h0;
    mem_access_task_done = 1'b0; mem_access_data_out = 32'h0;
    repeat (2) step();
    chk_outputs_zero("reset");
    rst_in = 1'b0;
    step();

    // Byte loads, signed then unsigned, adapter latency 2.
    r0_valid = 1'b1; r0_addr = 32'h100; r0_size = 2'b00; r0_signed = 1'b1;
    serve(1'b0, 32'h100, 2'b00, 32'h0, 2, 32'h000000F0, 32'hFFFFFFF0);
    r0_signed = 1'b0;
    serve(1'b0, 32'h100, 2'b00, 32'h0, 2, 32'h000000F0, 32'h000000F0);
    // Half signed, half unsigned with junk above, word, size 11 as word.
    r0_size = 2'b01; r0_signed = 1'b1; r0_addr = 32'h104;
    serve(1'b0, 32'h104, 2'b01, 32'h0, 1, 32'h00008001, 32'hFFFF8001);
    r0_signed = 1'b0;
    serve(1'b0, 32'h104, 2'b01, 32'h0, 1, 32'hABCD8001, 32'h00008001);
    r0_size = 2'b10; r0_signed = 1'b1; r0_addr = 32'h108;
    serve(1'b0, 32'h108, 2'b10, 32'h0, 1, 32'h80000000, 32'h80000000);
    r0_size = 2'b11;
    serve(1'b0, 32'h108, 2'b11, 32'h0, 1, 32'h8000FF80, 32'h8000FF80);
    // Requester drops valid right after the grant; done still arrives.
    r0_size = 2'b00; r0_signed = 1'b1; r0_addr = 32'h10C;
    step();
    r0_valid = 1'b0;
    chk("drop_issue_task", {31'd0, have_mem_access_task}, 32'd1);
    step();
    mem_access_task_done = 1'b1; mem_access_data_out = 32'h00000080;
    step();
    mem_access_task_done = 1'b0;
    chk("drop_r0_done", {31'd0, r0_done}, 32'd1);
    chk("drop_r0_data", r0_data, 32'hFFFFFF80);
    step();

    // Adapter done while IDLE is ignored.
    mem_access_task_done = 1'b1; mem_access_data_out = 32'h12;
    step();
    mem_access_task_done = 1'b0;
    chk("stray_done_task", {31'd0, have_mem_access_task}, 32'd0);
    step();
    chk("stray_done_resp", {30'd0, r0_done, r1_done}, 32'd0);
    chk("stray_done_data", r0_data, 32'hFFFFFF80);

    // Asynchronous reset in the middle of a store in BUSY.
    r1_valid = 1'b1; r1_addr = 32'h444; r1_size = 2'b10; r1_data = 32'h11112222;
    step();
    r1_valid = 1'b0;
    step();
    chk("prerst_wdata", mem_access_data, 32'h11112222);
    #2 rst_in = 1'b1;
    #1 chk_outputs_zero("async_rst");
    step();
    rst_in = 1'b0;
    step();

    // Ties after reset: r1, r0, r1, r0.
    r0_valid = 1'b1; r0_addr = 32'h300; r0_size = 2'b10; r0_signed = 1'b0;
    r1_valid = 1'b1; r1_addr = 32'h200; r1_size = 2'b10; r1_data = 32'hDEADBEEF;
    serve(1'b1, 32'h200, 2'b10, 32'hDEADBEEF, 1, 32'h0, 32'h0);
    serve(1'b0, 32'h300, 2'b10, 32'h0, 1, 32'h12345678, 32'h12345678);
    serve(1'b1, 32'h200, 2'b10, 32'hDEADBEEF, 2, 32'h0, 32'h12345678);
    serve(1'b0, 32'h300, 2'b10, 32'h0, 1, 32'hCAFEF00D, 32'hCAFEF00D);
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Flush in BUSY together with adapter done: no pulse, back to IDLE.
    r0_valid = 1'b1; r0_addr = 32'h500; r0_size = 2'b10;
    step();
    step();
    mem_access_task_done = 1'b1; mem_access_data_out = 32'h77777777; flush_pipline = 1'b1;
    step();
    mem_access_task_done = 1'b0; flush_pipline = 1'b0; r0_valid = 1'b0;
    chk("flush_done", {30'd0, r0_done, r1_done}, 32'd0);
    chk("flush_addr", mem_access_addr, 32'd0);
    chk("flush_task", {31'd0, have_mem_access_task}, 32'd0);
    chk("flush_r0_data", r0_data, 32'hCAFEF00D);
    r1_valid = 1'b1; r1_addr = 32'h600; r1_data = 32'h0BADCAFE;
    serve(1'b1, 32'h600, 2'b10, 32'h0BADCAFE, 1, 32'h0, 32'hCAFEF00D);
    r1_valid = 1'b0;

    // rdy_in low for 3 cycles in RESP: pulse held, then exactly one more edge.
    r0_valid = 1'b1; r0_addr = 32'h700; r0_size = 2'b10;
    step();
    step();
    mem_access_task_done = 1'b1; mem_access_data_out = 32'h55AA55AA;
    step();
    mem_access_task_done = 1'b0; rdy_in = 1'b0; r0_valid = 1'b0;
    chk("frz_enter_done", {31'd0, r0_done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_hold_done", {31'd0, r0_done}, 32'd1);
      chk("frz_hold_data", r0_data, 32'h55AA55AA);
    end
    rdy_in = 1'b1;
    step();
    chk("frz_release_done", {30'd0, r0_done, r1_done}, 32'd0);
    step();
    chk("frz_after_done", {30'd0, r0_done, r1_done}, 32'd0);
    chk("frz_after_task", {31'd0, have_mem_access_task}, 32'd0);
    chk("frz_after_data", r0_data, 32'h55AA55AA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-high.
REQ-002 The block SHALL provide these ports, one per line as name  direction  width  meaning:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; state frozen when low
- flush_pipline  in  1  synchronous abort of all work
- r0_valid  in  1  load requester (LSB) request; held until r0_done or flush
- r0_addr  in  32  load address
- r0_size  in  2  00 byte, 01 half, 10 word
- r0_signed  in  1  1 = sign-extend result, 0 = zero-extend
- r0_done  out  1  one-cycle pulse: load complete
- r0_data  out  32  extended load result, valid with r0_done
- r1_valid  in  1  store requester (commit) request; held until r1_done or flush
- r1_addr  in  32  store address
- r1_size  in  2  as r0_size
- r1_data  in  32  store data, low bytes used
- r1_done  out  1  one-cycle pulse: store complete
- have_mem_access_task  out  1  task strobe to memory adapter
- mem_access_addr  out  32  to adapter
- mem_access_rw  out  1  0 read, 1 write
- mem_access_size  out  2  to adapter
- mem_access_data  out  32  to adapter
- mem_access_task_done  in  1  adapter completion, one cycle
- mem_access_data_out  in  32  adapter read data, valid with done

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, BUSY, RESP.
REQ-004 IDLE: if any rX_valid, grant one requester, latch its addr/size/data/signed/rw into internal registers, go ISSUE.
REQ-005 Arbitration SHALL be round-robin: when both valid, grant the requester not granted last; last-grant pointer resets to r0, so r1 wins the first tie.
REQ-006 ISSUE: have_mem_access_task SHALL be 1 for exactly this one cycle, with mem_access_* driven from latched registers; next state BUSY.
REQ-007 mem_access_addr/rw/size/data SHALL hold latched values in ISSUE and BUSY; 0 in IDLE and RESP.
REQ-008 BUSY: wait for mem_access_task_done; on done, capture mem_access_data_out into result register, go RESP.
REQ-009 Result extension: byte takes bits 7:0, half takes bits 15:0; upper bits SHALL be sign bit (7 or 15) if signed, else 0; word passes unchanged; size 11 SHALL be treated as word.
REQ-010 RESP: pulse r0_done (with r0_data = result) or r1_done for the granted requester, exactly one cycle; next state IDLE.
REQ-011 Request-to-done latency SHALL be 3 + adapter latency cycles (IDLE, ISSUE, BUSY cycles through done, RESP); minimum request-to-request turnaround 1 idle cycle.
REQ-012 r0_data SHALL hold its last value outside r0_done; it is meaningful only with r0_done.
REQ-013 A requester dropping valid after grant SHALL NOT abort the transaction; the done pulse still issues.
REQ-014 flush_pipline high (rdy_in high) SHALL force IDLE from any state next cycle, suppress any pending done pulse, deassert have_mem_access_task; last-grant pointer kept.
REQ-015 flush has priority over mem_access_task_done in the same cycle: no done pulse.
REQ-016 rdy_in low SHALL freeze all registers and hold outputs; done pulses not lost or duplicated.
REQ-017 mem_access_task_done arriving outside BUSY SHALL be ignored.

Reset
REQ-018 On rst_in: state IDLE, last-grant r0, all outputs 0, result register 0, latched registers 0.

Verification
REQ-019 Scenarios a bench SHALL cover:
- r0 lb addr 0x100, signed, adapter returns 0x000000F0 after 2 cycles -> one r0_done, r0_data 0xFFFFFFF0; same with unsigned -> 0x000000F0.
- r0 and r1 asserted same cycle after reset -> r1 serviced first (rw=1, data passed), then r0; alternation over 4 back-to-back ties.
- flush in BUSY with done same cycle -> no r0_done/r1_done, IDLE next cycle, new request accepted.
- rdy_in low 3 cycles during RESP -> done pulse stays asserted only while frozen, exactly one effective pulse after release.
- lh signed, adapter data 0x00008001 -> r0_data 0xFFFF8001; lw 0x80000000 -> 0x80000000.
- rst_in asserted mid-BUSY asynchronously -> all outputs 0 immediately, IDLE.
